// File: rtl/dmem_responder.sv
// Data-side memory responder: latches one CPU access, waits WAIT_CYCLES, commits it
// to a byte-lane-writable word array and reports the result in a single DONE cycle.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        bus_error
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic                  commit;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           ram_rd_q;

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < LIMIT);
    assign commit   = (state_q == S_BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    state_d = S_BUSY;
                    addr_d  = mem_addr;
                    wen_d   = mem_wen;
                    wdata_d = mem_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    err_d   = !in_range;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wen_q   <= 4'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Unreset RAM with a registered read port; the read register captures the old word
    // on the commit edge, and the output gating below supplies the zero value elsewhere.
    always_ff @(posedge clk) begin
        if (commit) begin
            ram_rd_q <= mem[word_idx];
            if (in_range) begin
                for (int i = 0; i < 4; i++) begin
                    if (wen_q[i]) begin
                        mem[word_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
                    end
                end
            end
        end
    end

    assign mem_stall = rst && (((state_q == S_IDLE) && mem_en) || (state_q == S_BUSY));
    assign mem_rdata = ((state_q == S_DONE) && !err_q) ? ram_rd_q : 32'h0;
    assign bus_error = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/hold sequences and a
// randomized run checked against a word-map model of the memory.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic [3:0]  mem_wen = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        bus_error;

    logic        en0 = 1'b0;
    logic [3:0]  wen0 = 4'h0;
    logic [31:0] addr0 = 32'h0;
    logic [31:0] wdata0 = 32'h0;
    logic [31:0] rdata0;
    logic        stall0;
    logic        err0;

    int total = 0;
    int bad = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .bus_error(bus_error)
    );

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst), .mem_en(en0), .mem_wen(wen0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_stall(stall0),
        .bus_error(err0)
    );

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    function automatic logic model_in_range(input logic [31:0] a);
        return a < 32'h0000_4000;
    endfunction

    function automatic void model_apply(input logic [3:0] w, input logic [31:0] a,
                                        input logic [31:0] d);
        logic [31:0] word;
        int key;
        if (!model_in_range(a) || w == 4'h0) return;
        key  = int'(a >> 2);
        word = model.exists(key) ? model[key] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (w[i]) word[i*8 +: 8] = d[i*8 +: 8];
        model[key] = word;
    endfunction

    // One full access on the WAIT_CYCLES=2 instance plus one idle cycle after DONE.
    task automatic run_access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic er,
                              output int stalls, output int noise);
        bit done;
        @(posedge clk); #1;
        mem_en = 1'b1; mem_wen = w; mem_addr = a; mem_wdata = d;
        stalls = 0; noise = 0; rd = 32'h0; er = 1'b0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_stall) begin
                stalls++;
                if (mem_rdata !== 32'h0 || bus_error !== 1'b0) noise++;
            end else begin
                rd = mem_rdata; er = bus_error; done = 1;
            end
        end
        @(posedge clk); #1;
        mem_en = 1'b0; mem_wen = 4'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
        @(negedge clk);
        if (mem_stall !== 1'b0 || mem_rdata !== 32'h0 || bus_error !== 1'b0) noise++;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          stalls, noise;
        logic [3:0]  w;
        logic [31:0] a, d, exp_rd;
        logic        exp_er;

        //                wen    addr          wdata         chk  rd            er
        vecs[0]  = '{4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{4'hF, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{4'hF, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{4'h0, 32'h0000_0040, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[4]  = '{4'h4, 32'h0000_0040, 32'hABAB_ABAB, 1'b1, 32'h1234_5678, 1'b0};
        vecs[5]  = '{4'h0, 32'h0000_0040, 32'h0,         1'b1, 32'h12AB_5678, 1'b0};
        vecs[6]  = '{4'hF, 32'h0000_0080, 32'h0000_0001, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{4'hF, 32'h0000_0080, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0};
        vecs[8]  = '{4'h0, 32'h0000_0083, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{4'hF, 32'h0000_4000, 32'h5555_5555, 1'b1, 32'h0,         1'b1};
        vecs[10] = '{4'h0, 32'h0000_4000, 32'h0,         1'b1, 32'h0,         1'b1};
        vecs[11] = '{4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[12] = '{4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,         1'b1};
        vecs[13] = '{4'hF, 32'h0000_3FFC, 32'h0BAD_0BAD, 1'b0, 32'h0,         1'b0};
        vecs[14] = '{4'h0, 32'h0000_3FFF, 32'h0,         1'b1, 32'h0BAD_0BAD, 1'b0};

        // Reset state, with the request line idle.
        #12;
        check("reset_stall", 32'(mem_stall), 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_berr", 32'(bus_error), 32'h0);
        @(posedge clk); #1; rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_access(vecs[i].wen, vecs[i].addr, vecs[i].wdata, rd, er, stalls, noise);
            check($sformatf("vec%0d_stall", i), 32'(stalls), 32'd4);
            check($sformatf("vec%0d_quiet", i), 32'(noise), 32'd0);
            check($sformatf("vec%0d_berr", i), 32'(er), 32'(vecs[i].er));
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            model_apply(vecs[i].wen, vecs[i].addr, vecs[i].wdata);
        end

        // Reset in the middle of a write must abandon it.
        @(posedge clk); #1;
        mem_en = 1'b1; mem_wen = 4'hF; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midbusy_reset_stall", 32'(mem_stall), 32'h0);
        check("midbusy_reset_rdata", mem_rdata, 32'h0);
        check("midbusy_reset_berr", 32'(bus_error), 32'h0);
        mem_en = 1'b0;
        @(posedge clk); @(posedge clk); #1; rst = 1'b1;
        run_access(4'h0, 32'h10, 32'h0, rd, er, stalls, noise);
        check("after_reset_stall", 32'(stalls), 32'd4);
        check("after_reset_rdata", rd, 32'h1111_1111);

        // Zero-wait instance: latency, input hold and earliest next acceptance.
        @(posedge clk); #1;
        en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h20; wdata0 = 32'h7777_0000;
        repeat (3) @(posedge clk);
        #1; addr0 = 32'h24; wdata0 = 32'h2424_2424;
        repeat (3) @(posedge clk);
        #1; en0 = 1'b0;
        @(posedge clk); #1;
        en0 = 1'b1; wen0 = 4'h0; addr0 = 32'h20;
        @(negedge clk);
        check("w0_stall_c0", 32'(stall0), 32'h1);
        @(posedge clk); #1;
        en0 = 1'b0; addr0 = 32'h24;
        @(negedge clk);
        check("w0_stall_c1", 32'(stall0), 32'h1);
        @(posedge clk); #1;
        en0 = 1'b1;
        @(negedge clk);
        check("w0_done_stall", 32'(stall0), 32'h0);
        check("w0_done_rdata", rdata0, 32'h7777_0000);
        @(posedge clk); #1;
        @(negedge clk);
        check("w0_next_accept", 32'(stall0), 32'h1);
        @(posedge clk); @(posedge clk); #1;
        en0 = 1'b0;
        @(negedge clk);
        check("w0_next_rdata", rdata0, 32'h2424_2424);

        // Randomized traffic over a small window plus some out-of-range addresses.
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            run_access(4'hF, 32'h200 + 32'(4 * k), d, rd, er, stalls, noise);
            check($sformatf("fill%0d_stall", k), 32'(stalls), 32'd4);
            model_apply(4'hF, 32'h200 + 32'(4 * k), d);
        end
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h0000_4000 + 32'($urandom_range(0, 255));
                1:       a = 32'h8000_0000 | 32'($urandom_range(0, 255));
                default: a = 32'h200 + 32'($urandom_range(0, 31));
            endcase
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            d = $urandom;
            exp_er = !model_in_range(a);
            exp_rd = exp_er ? 32'h0 : model[int'(a >> 2)];
            run_access(w, a, d, rd, er, stalls, noise);
            check($sformatf("rnd%0d_stall", n), 32'(stalls), 32'd4);
            check($sformatf("rnd%0d_quiet", n), 32'(noise), 32'd0);
            check($sformatf("rnd%0d_berr", n), 32'(er), 32'(exp_er));
            check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            model_apply(w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
